// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM state encoding and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch stage: jump beats branch, branch beats sequential.
module fetch_next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [25:0]       instr_idx,
  input  logic [31:0]       branch_imm,
  input  logic              pc_src,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] w_jump_target;
  logic [ADDR_W-1:0] w_branch_target;

  assign w_jump_target   = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};
  // Offset is in words; the shift drops the top two bits so the add wraps naturally.
  assign w_branch_target = pc_plus4 + ADDR_W'({branch_imm[29:0], 2'b00});

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = w_jump_target;
    end else if (pc_src) begin
      next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding req/gnt + rvalid access, instruction held until commit.
// Optional perf counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_src,
  input  logic              jump,
  input  logic [31:0]       branch_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              w_capture;
  logic              w_commit;
  logic [ADDR_W-1:0] w_next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          w_commit     = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (w_capture) r_instr <= imem_rdata;
      if (w_commit)  r_pc    <= w_next_pc;
    end
  end

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4   (pc_plus4),
    .instr_idx  (r_instr[25:0]),
    .branch_imm (branch_imm),
    .pc_src     (pc_src),
    .jump       (jump),
    .next_pc    (w_next_pc)
  );

  assign imem_addr = {r_pc[ADDR_W-1:2], 2'b00};
  assign pc        = r_pc;
  assign pc_plus4  = r_pc + ADDR_W'(4);
  assign instr     = r_instr;
  assign opcode    = r_instr[31:26];
  assign funct     = r_instr[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == S_REQ)  && !imem_gnt)    ||
                   ((r_state == S_WAIT) && !imem_rvalid) ||
                   ((r_state == S_HOLD) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_commit) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an address/instruction scoreboard; a second
// instance starting at 0xFFFF_FFFC covers PC wrap. Counter checks build with FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, pc_src, jump;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, branch_imm;
  logic [5:0]  opcode, funct;

  logic        w_imem_req, w_imem_gnt, w_imem_rvalid, w_instr_valid, w_instr_ready;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_pc, w_pc_plus4;
  logic [5:0]  w_opcode, w_funct;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .jump(jump), .branch_imm(branch_imm)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_imem_gnt),
    .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
    .instr(w_instr), .opcode(w_opcode), .funct(w_funct), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .pc_src(1'b0), .jump(1'b0), .branch_imm(32'h0)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(w_fetch_cnt), .stall_cnt(w_stall_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_fetch = 0;
  int          exp_stall = 0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] cur_addr, cur_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fetch_cnt"}, fetch_cnt, 32'(exp_fetch));
    check({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  // Serve one fetch: gnt after gnt_delay cycles (stray rvalid meanwhile), rvalid next cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int gnt_delay);
    logic [31:0] exp_a, exp_i;
    addr_q.push_back(addr);
    instr_q.push_back(data);
    wait_req("fetch");
    exp_a = addr_q.pop_front();
    check("imem_addr", imem_addr, exp_a);
    for (int i = 0; i < gnt_delay; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("req_hold_req", 32'(imem_req), 32'd1);
      check("req_hold_addr", imem_addr, exp_a);
      check("req_hold_valid", 32'(instr_valid), 32'd0);
      exp_stall++;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req_low", 32'(imem_req), 32'd0);
    check("wait_valid_low", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    exp_i = instr_q.pop_front();
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, exp_i);
    check("opcode", 32'(opcode), 32'(exp_i[31:26]));
    check("funct", 32'(funct), 32'(exp_i[5:0]));
    check("pc", pc, exp_a);
    check("pc_plus4", pc_plus4, exp_a + 32'd4);
    cur_addr  = exp_a;
    cur_instr = exp_i;
  endtask

  task automatic commit(input logic src, input logic jmp, input logic [31:0] imm, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      exp_stall++;
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_pc", pc, cur_addr);
      check("hold_instr", instr, cur_instr);
    end
    instr_ready = 1'b1;
    pc_src      = src;
    jump        = jmp;
    branch_imm  = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    jump        = 1'b0;
    branch_imm  = 32'h0;
    exp_fetch++;
    check("commit_valid_low", 32'(instr_valid), 32'd0);
    check_cnt("commit");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ready = 0; pc_src = 0; jump = 0; branch_imm = 0;
    w_imem_gnt = 0; w_imem_rvalid = 0; w_imem_rdata = 0; w_instr_ready = 0;

    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    check_cnt("rst");

    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    fetch(32'h0, 32'h2008_0005, 0);       // addi
    commit(1'b0, 1'b0, 32'h0, 0);         // -> 0x4
    fetch(32'h4, 32'h0800_0004, 0);       // j 0x10
    commit(1'b0, 1'b1, 32'h0, 0);
    fetch(32'h10, 32'h1000_FFFF, 2);      // beq, late gnt
    commit(1'b1, 1'b0, 32'hFFFF_FFFC, 0); // 0x14 - 16 = 0x4
    fetch(32'h4, 32'h0800_0004, 0);
    commit(1'b0, 1'b1, 32'h0, 0);
    fetch(32'h10, 32'h1000_FFFF, 0);
    commit(1'b0, 1'b0, 32'hFFFF_FFFC, 0); // not taken -> 0x14
    fetch(32'h14, 32'h0800_0040, 0);
    commit(1'b0, 1'b1, 32'h0, 0);         // -> 0x100
    fetch(32'h100, 32'h0800_0040, 0);
    commit(1'b1, 1'b1, 32'h5, 0);         // jump wins -> 0x100
    fetch(32'h100, 32'h8C02_0008, 0);     // lw, backpressure
    commit(1'b0, 1'b0, 32'h0, 5);         // -> 0x104

    // Reset while in S_WAIT
    wait_req("mid");
    check("mid_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    exp_fetch = 0;
    exp_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;                   // stray pulse in S_IDLE
    imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("stray_valid", 32'(instr_valid), 32'd0);
    check("stray_instr", instr, 32'h0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    check_cnt("restart");
    fetch(32'h0, 32'h2009_000A, 0);
    commit(1'b0, 1'b0, 32'h0, 0);
    fetch(32'h4, 32'h0000_0020, 0);

    // Wrap instance (stalled in S_REQ since reset release)
    check("wrap_req", 32'(w_imem_req), 32'd1);
    check("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_gnt = 1'b1;
    @(negedge clk);
    w_imem_gnt = 1'b0;
    w_imem_rvalid = 1'b1;
    w_imem_rdata  = 32'h0000_0020;
    @(negedge clk);
    w_imem_rvalid = 1'b0;
    check("wrap_valid", 32'(w_instr_valid), 32'd1);
    check("wrap_pc_plus4", w_pc_plus4, 32'h0);
    w_instr_ready = 1'b1;
    @(negedge clk);
    w_instr_ready = 1'b0;
    check("wrap_next_req", 32'(w_imem_req), 32'd1);
    check("wrap_next_addr", w_imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
